// File: rtl/serve_scheduler_if.sv
// Handshake bundle between the input sync/UART logic, the serve scheduler and the ball FSM.
interface serve_scheduler_if;
    logic       end_of_frame;
    logic       screen_idle;
    logic       screen_multi;
    logic       btn_serve_p1;
    logic       btn_serve_p2;
    logic [3:0] points_player_1;
    logic [3:0] points_player_2;
    logic [1:0] who_won;
    logic       serve;
    logic       server_id;
    logic [3:0] countdown;
    logic       serve_armed;

    // Upstream / environment side: drives frame, menu, button and score inputs.
    modport master (
        output end_of_frame, screen_idle, screen_multi, btn_serve_p1, btn_serve_p2,
               points_player_1, points_player_2, who_won,
        input  serve, server_id, countdown, serve_armed
    );

    // Scheduler side.
    modport slave (
        input  end_of_frame, screen_idle, screen_multi, btn_serve_p1, btn_serve_p2,
               points_player_1, points_player_2, who_won,
        output serve, server_id, countdown, serve_armed
    );
endinterface

// File: rtl/serve_scheduler.sv
// Serve scheduler: picks the server, runs the frame-based pre-serve countdown and
// emits the one-cycle serve strobe that restarts the ball FSM.
//
// state | meaning
// IDLE  | menu shown, nothing counting
// COUNT | countdown running, decremented every FRAMES_PER_TICK frames
// ARMED | waiting for the server's button or the auto-serve timeout
// RALLY | ball in play, waiting for a score change
// END   | game decided, any button press returns the ball FSM to IDLE
module serve_scheduler #(
    parameter int COUNT_START     = 3,
    parameter int FRAMES_PER_TICK = 60,
    parameter int TIMEOUT_FRAMES  = 300
) (
    input logic               clk65MHz,
    input logic               rst_n,
    serve_scheduler_if.slave  bus
);

    localparam int TICK_W = $clog2(FRAMES_PER_TICK) + 1;
    localparam int TO_W   = $clog2(TIMEOUT_FRAMES) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAMES_PER_TICK - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_FRAMES - 1);
    localparam logic [3:0]        CNT_INIT  = 4'(COUNT_START);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_ARMED = 3'd2,
        S_RALLY = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]        countdown_q, countdown_d;
    logic              server_id_q, server_id_d;
    logic              serve_q, serve_d;
    logic              serve_armed_q, serve_armed_d;
    logic              btn_p1_q, btn_p2_q;
    logic [3:0]        pts_p1_q, pts_p2_q;

    logic rise_p1, rise_p2, server_rise, score_p1, score_p2;

    // In single-player mode the second button never counts as a press.
    assign rise_p1     = bus.btn_serve_p1 & ~btn_p1_q;
    assign rise_p2     = bus.btn_serve_p2 & ~btn_p2_q & bus.screen_multi;
    assign server_rise = server_id_q ? rise_p2 : rise_p1;
    assign score_p1    = (bus.points_player_1 != pts_p1_q);
    assign score_p2    = (bus.points_player_2 != pts_p2_q);

    // Next-state, counter and output computation.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        to_cnt_d    = to_cnt_q;
        countdown_d = countdown_q;
        server_id_d = server_id_q;
        serve_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.screen_idle) begin
                    state_d     = S_COUNT;
                    countdown_d = CNT_INIT;
                    tick_cnt_d  = '0;
                    server_id_d = 1'b0;
                end
            end
            S_COUNT: begin
                if (bus.end_of_frame) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d  = '0;
                        countdown_d = countdown_q - 4'd1;
                        if (countdown_q == 4'd1) begin
                            state_d  = S_ARMED;
                            to_cnt_d = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            S_ARMED: begin
                // A press takes precedence over a coincident frame tick; either way one pulse.
                if (server_rise) begin
                    serve_d = 1'b1;
                    state_d = S_RALLY;
                end else if (bus.end_of_frame) begin
                    if (to_cnt_q == TO_LAST) begin
                        serve_d = 1'b1;
                        state_d = S_RALLY;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            S_RALLY: begin
                if (score_p1 || score_p2) begin
                    // The player who lost the point serves; P1 scoring wins a tie.
                    server_id_d = score_p1 ? bus.screen_multi : 1'b0;
                    if (bus.who_won != 2'd0) begin
                        state_d = S_END;
                    end else begin
                        state_d     = S_COUNT;
                        countdown_d = CNT_INIT;
                        tick_cnt_d  = '0;
                    end
                end
            end
            S_END: begin
                if (rise_p1 || rise_p2) begin
                    serve_d     = 1'b1;
                    state_d     = S_IDLE;
                    countdown_d = 4'd0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                countdown_d = 4'd0;
            end
        endcase

        // The menu overrides everything.
        if (bus.screen_idle) begin
            state_d     = S_IDLE;
            serve_d     = 1'b0;
            countdown_d = 4'd0;
        end

        serve_armed_d = (state_d == S_ARMED);
    end

    // State, counters, registered outputs and input history.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            to_cnt_q      <= '0;
            countdown_q   <= 4'd0;
            server_id_q   <= 1'b0;
            serve_q       <= 1'b0;
            serve_armed_q <= 1'b0;
            btn_p1_q      <= 1'b0;
            btn_p2_q      <= 1'b0;
            pts_p1_q      <= 4'd0;
            pts_p2_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            to_cnt_q      <= to_cnt_d;
            countdown_q   <= countdown_d;
            server_id_q   <= server_id_d;
            serve_q       <= serve_d;
            serve_armed_q <= serve_armed_d;
            btn_p1_q      <= bus.btn_serve_p1;
            btn_p2_q      <= bus.btn_serve_p2;
            pts_p1_q      <= bus.points_player_1;
            pts_p2_q      <= bus.points_player_2;
        end
    end

    assign bus.serve       = serve_q;
    assign bus.server_id   = server_id_q;
    assign bus.countdown   = countdown_q;
    assign bus.serve_armed = serve_armed_q;

endmodule
